load_store_unit: RTL and testbench

- Sits directly downstream of the ALU in the single-stage RV32 core.
- Consumes the ALU result as the effective address of a load or store.
- Drives a request/grant/response data-memory port and holds the core via stall while the access is in flight.
- Returns byte/half/word load data, sign- or zero-extended, to writeback, and flags misaligned or invalid accesses.

---
 rtl/load_store_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit: request/grant/response data-memory port, byte lanes, load extension.
// Optional watchdog on stalled accesses is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             stall,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic             r_fault;
  logic [WIDTH-1:0] r_rsp_rdata;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [3:0]       r_mem_be;
  logic             w_legal;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_lane;
  logic [WIDTH-1:0] w_ext;
  logic             w_tmo;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] r_tmo_cnt;
  assign w_tmo = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                 (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // Legality, byte enables and lane-replicated store data for the presented request
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = {WIDTH{1'b0}};
    case (req_funct3)
      3'b000: begin
        w_legal = 1'b1;
        if (req_we) begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end else begin
          w_be    = 4'b1111;
        end
      end
      3'b001: begin
        w_legal = ~req_addr[0];
        if (req_we) begin
          w_be    = 4'b0011 << req_addr[1:0];
          w_wdata = {2{req_wdata[15:0]}};
        end else begin
          w_be    = 4'b1111;
        end
      end
      3'b010: begin
        w_legal = (req_addr[1:0] == 2'b00);
        if (req_we) begin
          w_wdata = req_wdata;
        end else begin
          w_wdata = {WIDTH{1'b0}};
        end
      end
      3'b100:  w_legal = ~req_we;
      3'b101:  w_legal = ~req_we & ~req_addr[0];
      default: w_legal = 1'b0;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched access type
  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    case (r_f3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_ext = {24'h000000, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_ext = {16'h0000, w_lane[15:0]};
      3'b010:  w_ext = mem_rdata;
      default: w_ext = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = w_legal ? S_REQ : S_RESP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_tmo)        w_next = S_RESP;
        else if (mem_gnt) w_next = S_WAIT;
        else              w_next = S_REQ;
      end
      S_WAIT: begin
        if (w_tmo || mem_rvalid) w_next = S_RESP;
        else                     w_next = S_WAIT;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Access latch, memory port registers and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
      r_fault     <= 1'b0;
      r_rsp_rdata <= {WIDTH{1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {WIDTH{1'b0}};
      r_mem_wdata <= {WIDTH{1'b0}};
      r_mem_be    <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt   <= {TW{1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_off   <= req_addr[1:0];
            r_fault <= ~w_legal;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt <= {TW{1'b0}};
`endif
            if (w_legal) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_be    <= w_be;
            end
          end
        end
        S_REQ: begin
`ifdef LSU_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          // Port registers clear once the request is taken so the idle bus is quiet
          if (mem_gnt || w_tmo) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {WIDTH{1'b0}};
            r_mem_wdata <= {WIDTH{1'b0}};
            r_mem_be    <= 4'b0000;
          end
          if (w_tmo) r_fault <= 1'b1;
        end
        S_WAIT: begin
`ifdef LSU_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          if (w_tmo) begin
            r_fault     <= 1'b1;
            r_rsp_rdata <= {WIDTH{1'b0}};
          end else if (mem_rvalid) begin
            r_rsp_rdata <= r_we ? {WIDTH{1'b0}} : w_ext;
          end
        end
        S_RESP: begin
          r_fault     <= 1'b0;
          r_rsp_rdata <= {WIDTH{1'b0}};
        end
        default: r_fault <= 1'b0;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign stall     = (r_state == S_REQ) || (r_state == S_WAIT) ||
                     ((r_state == S_IDLE) && req_valid);
  assign rsp_rdata = r_rsp_rdata;
  assign fault     = r_fault;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected responses,
// a monitor pops and compares on every rsp_valid.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, stall, rsp_valid, fault;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h fault %0b with nothing expected", rsp_rdata, fault);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({fault, rsp_rdata} !== e) begin
          fails++;
          $display("FAIL rsp: got fault %0b rdata 0x%08h expected fault %0b rdata 0x%08h",
                   fault, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic access(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_dly, input logic legal,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    exp_q.push_back({~legal, e_rdata});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    check({nm, "_stall_T"}, {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    if (!legal) begin
      req_valid = 1'b0; #1;
      check({nm, "_noreq"}, {31'd0, mem_req}, 32'd0);
      check({nm, "_rsp_T1"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, "_stall_resp"}, {31'd0, stall}, 32'd0);
    end else begin
      check({nm, "_req"}, {31'd0, mem_req}, 32'd1);
      check({nm, "_we"}, {31'd0, mem_we}, {31'd0, we});
      check({nm, "_addr"}, mem_addr, e_addr);
      check({nm, "_be"}, {28'd0, mem_be}, {28'd0, e_be});
      check({nm, "_wdata"}, mem_wdata, e_wdata);
      for (int i = 0; i < gnt_dly; i++) begin
        @(negedge clk); #1;
        check({nm, "_req_hold"}, {31'd0, mem_req}, 32'd1);
        check({nm, "_addr_hold"}, mem_addr, e_addr);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; #1;
      check({nm, "_req_drop"}, {31'd0, mem_req}, 32'd0);
      check({nm, "_stall_wait"}, {31'd0, stall}, 32'd1);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0; req_valid = 1'b0; #1;
      check({nm, "_rsp_lat"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, "_stall_resp"}, {31'd0, stall}, 32'd0);
    end
    @(negedge clk); #1;
    check({nm, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    access("lw",    1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'h1000, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("lb",    1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 1'b1, 32'h1000, 4'b1111, 32'h0, 32'hFFFFFF80);
    access("lbu",   1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 1, 1'b1, 32'h1000, 4'b1111, 32'h0, 32'h00000080);
    access("lhu",   1'b0, 3'b101, 32'h1002, 32'h0, 32'h80FF1234, 0, 1'b1, 32'h1000, 4'b1111, 32'h0, 32'h000080FF);
    access("lh",    1'b0, 3'b001, 32'h1002, 32'h0, 32'h80FF1234, 0, 1'b1, 32'h1000, 4'b1111, 32'h0, 32'hFFFF80FF);
    access("lh_lo", 1'b0, 3'b001, 32'h1000, 32'h0, 32'h80FF7234, 0, 1'b1, 32'h1000, 4'b1111, 32'h0, 32'h00007234);
    access("sb",    1'b1, 3'b000, 32'h2002, 32'h000000AB, 32'hFFFFFFFF, 0, 1'b1, 32'h2000, 4'b0100, 32'hABABABAB, 32'h0);
    access("sh",    1'b1, 3'b001, 32'h2002, 32'h1234CDEF, 32'hFFFFFFFF, 0, 1'b1, 32'h2000, 4'b1100, 32'hCDEFCDEF, 32'h0);
    access("sw",    1'b1, 3'b010, 32'h2004, 32'h12345678, 32'hFFFFFFFF, 2, 1'b1, 32'h2004, 4'b1111, 32'h12345678, 32'h0);
    access("lw_mis", 1'b0, 3'b010, 32'h1001, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0);
    access("sh_mis", 1'b1, 3'b001, 32'h0003, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0);
    access("f3_011", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0);
    access("sbu",    1'b1, 3'b100, 32'h1000, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0);

    // Abandoned access: reset lands in WAIT, the late response must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000;
    repeat (3) @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("arst_memreq", {31'd0, mem_req}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("arst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0; #1;
    check("late_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
    check("late_rvalid_ready", {31'd0, req_ready}, 32'd1);
    access("lw_after", 1'b0, 3'b010, 32'h1004, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'h1004, 4'b1111, 32'h0, 32'hCAFEF00D);

`ifdef LSU_TIMEOUT_EN
    begin
      int n;
      n = 0;
      exp_q.push_back({1'b1, 32'h0});
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4000;
      @(negedge clk); #1;
      while (stall && n < 40) begin
        n++;
        @(negedge clk); #1;
      end
      req_valid = 1'b0;
      check("tmo_cycles", n, 32'd8);
      check("tmo_rsp", {31'd0, rsp_valid}, 32'd1);
      check("tmo_memreq", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
